serial_dft_bank: RTL and testbench

Multi-channel, multi-bin serial DFT accumulator. It takes one sample per channel per valid_i beat and accumulates x·w_re and x·w_im for BINS frequency bins at the same time. It generates its own per-bin twiddle indices for an external twiddle ROM. Completed frames are captured into a result buffer and streamed out one (channel, bin) pair per beat over a valid/ready interface, with overflow and saturation reporting.

---
 rtl/serial_dft_bank.sv | 181 ++++++++++++++++++
 tb/tb_serial_dft_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_dft_bank.sv
// rtl/serial_dft_bank.sv - multi-channel, multi-bin serial DFT accumulator
// with twiddle index generation and a drained result buffer.
module serial_dft_bank #(
  parameter int W_WIDTH      = 16,
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 32,
  parameter int FRAME_LENGTH = 8,
  parameter int CHANELS      = 2,
  parameter int BINS         = 4,
  localparam int LW = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1,
  localparam int CW = (CHANELS > 1) ? $clog2(CHANELS) : 1,
  localparam int BW = (BINS > 1) ? $clog2(BINS) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        valid_i,
  input  logic                        sync_i,
  input  logic [CHANELS*X_WIDTH-1:0]  x,
  output logic [BINS*LW-1:0]          tw_idx,
  input  logic [BINS*W_WIDTH-1:0]     w_re,
  input  logic [BINS*W_WIDTH-1:0]     w_im,
  output logic [LW-1:0]               sample_cnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [S_WIDTH-1:0]   out_re,
  output logic signed [S_WIDTH-1:0]   out_im,
  output logic [CW-1:0]               out_chan,
  output logic [BW-1:0]               out_bin,
  output logic                        out_last,
  output logic                        overflow,
  output logic                        sat
);

  localparam int PW = W_WIDTH + X_WIDTH;
  localparam logic [S_WIDTH-1:0] S_MAX = {1'b0, {(S_WIDTH-1){1'b1}}};
  localparam logic [S_WIDTH-1:0] S_MIN = {1'b1, {(S_WIDTH-1){1'b0}}};

  logic [LW-1:0]              phase     [BINS];
  logic [LW-1:0]              phase_nxt [BINS];
  logic [LW:0]                psum;
  logic [LW-1:0]              n_eff;
  logic [LW-1:0]              cnt_nxt;
  logic signed [S_WIDTH-1:0]  acc_re [CHANELS][BINS];
  logic signed [S_WIDTH-1:0]  acc_im [CHANELS][BINS];
  logic signed [S_WIDTH-1:0]  nxt_re [CHANELS][BINS];
  logic signed [S_WIDTH-1:0]  nxt_im [CHANELS][BINS];
  logic signed [S_WIDTH-1:0]  buf_re [CHANELS][BINS];
  logic signed [S_WIDTH-1:0]  buf_im [CHANELS][BINS];
  logic signed [S_WIDTH-1:0]  p_re, p_im;
  logic [S_WIDTH:0]           r_re, r_im;
  logic                       sat_hit;
  logic                       frame_done;
  logic                       load_buf;

  function automatic logic signed [S_WIDTH-1:0] mul(
    input logic signed [X_WIDTH-1:0] a,
    input logic signed [W_WIDTH-1:0] b
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return S_WIDTH'(p);
  endfunction

  // Returns {saturated, clamped_sum}.
  function automatic logic [S_WIDTH:0] sat_add(
    input logic [S_WIDTH-1:0] a,
    input logic [S_WIDTH-1:0] b
  );
    logic [S_WIDTH:0] s;
    s = {a[S_WIDTH-1], a} + {b[S_WIDTH-1], b};
    if (s[S_WIDTH] != s[S_WIDTH-1])
      return {1'b1, s[S_WIDTH] ? S_MIN : S_MAX};
    return {1'b0, s[S_WIDTH-1:0]};
  endfunction

  // A sync beat is sample 0 of a fresh frame, so phases read as zero this cycle.
  always_comb begin
    n_eff  = sync_i ? '0 : sample_cnt;
    tw_idx = '0;
    psum   = '0;
    for (int k = 0; k < BINS; k++) begin
      tw_idx[k*LW +: LW] = sync_i ? '0 : phase[k];
      psum = {1'b0, tw_idx[k*LW +: LW]} + (LW+1)'(k);
      if (psum >= (LW+1)'(FRAME_LENGTH))
        psum = psum - (LW+1)'(FRAME_LENGTH);
      phase_nxt[k] = psum[LW-1:0];
    end
    frame_done = valid_i && (n_eff == LW'(FRAME_LENGTH-1));
    cnt_nxt    = frame_done ? '0 : n_eff + LW'(1);
    load_buf   = frame_done && (!out_valid || (out_ready && out_last));
  end

  always_comb begin
    sat_hit = 1'b0;
    p_re    = '0;
    p_im    = '0;
    r_re    = '0;
    r_im    = '0;
    for (int c = 0; c < CHANELS; c++) begin
      for (int k = 0; k < BINS; k++) begin
        p_re = mul(x[c*X_WIDTH +: X_WIDTH], w_re[k*W_WIDTH +: W_WIDTH]);
        p_im = mul(x[c*X_WIDTH +: X_WIDTH], w_im[k*W_WIDTH +: W_WIDTH]);
        r_re = sat_add(acc_re[c][k], p_re);
        r_im = sat_add(acc_im[c][k], p_im);
        if (n_eff == '0) begin
          nxt_re[c][k] = p_re;
          nxt_im[c][k] = p_im;
        end else begin
          nxt_re[c][k] = r_re[S_WIDTH-1:0];
          nxt_im[c][k] = r_im[S_WIDTH-1:0];
          sat_hit = sat_hit | r_re[S_WIDTH] | r_im[S_WIDTH];
        end
      end
    end
  end

  always_comb begin
    out_re   = '0;
    out_im   = '0;
    out_last = out_valid && (out_chan == CW'(CHANELS-1)) && (out_bin == BW'(BINS-1));
    for (int c = 0; c < CHANELS; c++)
      for (int k = 0; k < BINS; k++)
        if (out_chan == CW'(c) && out_bin == BW'(k)) begin
          out_re = buf_re[c][k];
          out_im = buf_im[c][k];
        end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sample_cnt <= '0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_bin    <= '0;
      overflow   <= 1'b0;
      sat        <= 1'b0;
      for (int k = 0; k < BINS; k++) phase[k] <= '0;
      for (int c = 0; c < CHANELS; c++)
        for (int k = 0; k < BINS; k++) begin
          acc_re[c][k] <= '0;
          acc_im[c][k] <= '0;
          buf_re[c][k] <= '0;
          buf_im[c][k] <= '0;
        end
    end else begin
      if (valid_i) begin
        sample_cnt <= cnt_nxt;
        phase      <= phase_nxt;
        acc_re     <= nxt_re;
        acc_im     <= nxt_im;
        sat        <= sat | sat_hit;
      end else if (sync_i) begin
        sample_cnt <= '0;
        for (int k = 0; k < BINS; k++) phase[k] <= '0;
      end
      if (load_buf) begin
        buf_re    <= nxt_re;
        buf_im    <= nxt_im;
        out_valid <= 1'b1;
        out_chan  <= '0;
        out_bin   <= '0;
      end else begin
        // A frame finishing while an older one is still draining is dropped.
        if (frame_done) overflow <= 1'b1;
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_bin   <= '0;
          end else if (out_bin == BW'(BINS-1)) begin
            out_bin  <= '0;
            out_chan <= out_chan + CW'(1);
          end else begin
            out_bin <= out_bin + BW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_dft_bank.sv
// tb/tb_serial_dft_bank.sv - directed-vector bench for serial_dft_bank
// (N=4, 2 channels, 3 bins, S = W + X so saturation is reachable).
module tb_serial_dft_bank;
  localparam int W = 16, X = 16, S = 32, N = 4, C = 2, B = 3;
  localparam int LW = 2, CW = 1, BW = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              valid_i, sync_i;
  logic [C*X-1:0]    x;
  logic [B*LW-1:0]   tw_idx;
  logic [B*W-1:0]    w_re, w_im;
  logic [LW-1:0]     sample_cnt;
  logic              out_valid, out_ready, out_last, overflow, sat;
  logic signed [S-1:0] out_re, out_im;
  logic [CW-1:0]     out_chan;
  logic [BW-1:0]     out_bin;
  logic              sat_mode;

  int tests = 0;
  int fails = 0;

  logic signed [31:0] exp_re [3][C][B];
  logic signed [31:0] exp_im [3][C][B];
  int smp [2][N][C];
  int tw1 [N];
  int tw2 [N];

  serial_dft_bank #(
    .W_WIDTH(W), .X_WIDTH(X), .S_WIDTH(S),
    .FRAME_LENGTH(N), .CHANELS(C), .BINS(B)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .sync_i(sync_i), .x(x),
    .tw_idx(tw_idx), .w_re(w_re), .w_im(w_im), .sample_cnt(sample_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_chan(out_chan), .out_bin(out_bin), .out_last(out_last),
    .overflow(overflow), .sat(sat)
  );

  always #5 clk = ~clk;

  // Twiddle ROM for N=4: index -> (cos, -sin).
  always_comb begin
    w_re = '0;
    w_im = '0;
    for (int k = 0; k < B; k++) begin
      if (sat_mode) begin
        w_re[k*W +: W] = 16'h8000;
        w_im[k*W +: W] = 16'h8000;
      end else begin
        case (tw_idx[k*LW +: LW])
          2'd0: begin w_re[k*W +: W] = 16'sd1;  w_im[k*W +: W] = 16'sd0;  end
          2'd1: begin w_re[k*W +: W] = 16'sd0;  w_im[k*W +: W] = -16'sd1; end
          2'd2: begin w_re[k*W +: W] = -16'sd1; w_im[k*W +: W] = 16'sd0;  end
          default: begin w_re[k*W +: W] = 16'sd0; w_im[k*W +: W] = 16'sd1; end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_x(input int a, input int b);
    x[15:0]  = 16'(a);
    x[31:16] = 16'(b);
  endtask

  task automatic send_frame(input int f);
    for (int n = 0; n < N; n++) begin
      set_x(smp[f][n][0], smp[f][n][1]);
      valid_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  // Checks every beat with out_ready=1; optionally feeds frame nf so that it
  // completes on the same edge as the final handshake.
  task automatic drain(input int f, input int nf);
    for (int i = 0; i < C*B; i++) begin
      check($sformatf("f%0d b%0d valid", f, i), out_valid, 1);
      check($sformatf("f%0d b%0d chan", f, i), out_chan, i / B);
      check($sformatf("f%0d b%0d bin", f, i), out_bin, i % B);
      check($sformatf("f%0d b%0d re", f, i), out_re, exp_re[f][i/B][i%B]);
      check($sformatf("f%0d b%0d im", f, i), out_im, exp_im[f][i/B][i%B]);
      check($sformatf("f%0d b%0d last", f, i), out_last, (i == C*B-1) ? 1 : 0);
      if (nf >= 0 && i >= C*B-N) begin
        set_x(smp[nf][i-(C*B-N)][0], smp[nf][i-(C*B-N)][1]);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    smp[0] = '{'{1, 5}, '{2, -1}, '{3, 0}, '{4, 2}};
    smp[1] = '{'{2, -4}, '{0, 1}, '{-1, 1}, '{3, 0}};
    exp_re[0] = '{'{10, -2, -2}, '{6, 5, 4}};
    exp_im[0] = '{'{0, 2, 0}, '{0, 3, 0}};
    exp_re[1] = '{'{4, 3, -2}, '{-2, -5, -4}};
    exp_im[1] = '{'{0, 3, 0}, '{0, -1, 0}};
    exp_re[2] = '{'{32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff}, '{32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff}};
    exp_im[2] = exp_re[2];
    tw1 = '{0, 1, 2, 3};
    tw2 = '{0, 2, 0, 2};

    rstn = 1'b0; valid_i = 1'b0; sync_i = 1'b0; x = '0; out_ready = 1'b0; sat_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_re", out_re, 0);
    check("rst out_im", out_im, 0);
    check("rst out_last", out_last, 0);
    check("rst out_chan", out_chan, 0);
    check("rst out_bin", out_bin, 0);
    check("rst overflow", overflow, 0);
    check("rst sat", sat, 0);
    check("rst sample_cnt", sample_cnt, 0);
    check("rst tw_idx", tw_idx, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Frame A with phase checks, then frame B overlapping A's drain.
    for (int n = 0; n < N; n++) begin
      check($sformatf("A n%0d cnt", n), sample_cnt, n);
      check($sformatf("A n%0d tw0", n), tw_idx[1:0], 0);
      check($sformatf("A n%0d tw1", n), tw_idx[3:2], tw1[n]);
      check($sformatf("A n%0d tw2", n), tw_idx[5:4], tw2[n]);
      set_x(smp[0][n][0], smp[0][n][1]);
      valid_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
    drain(0, 1);
    drain(1, -1);
    check("b2b idle", out_valid, 0);
    check("b2b overflow", overflow, 0);
    check("b2b sat", sat, 0);

    // Stalled drain: second frame is dropped.
    out_ready = 1'b0;
    send_frame(0);
    repeat (20) @(negedge clk);
    check("stall valid", out_valid, 1);
    check("stall re", out_re, 10);
    send_frame(1);
    check("ovf flag", overflow, 1);
    check("ovf re held", out_re, 10);
    check("ovf bin held", out_bin, 0);
    drain(0, -1);
    check("ovf lost frame", out_valid, 0);

    // Sync without and with a sample.
    out_ready = 1'b1;
    set_x(smp[1][0][0], smp[1][0][1]); valid_i = 1'b1; @(negedge clk);
    set_x(smp[1][1][0], smp[1][1][1]); @(negedge clk);
    valid_i = 1'b0;
    check("pre-sync cnt", sample_cnt, 2);
    sync_i = 1'b1;
    #1 check("sync-only tw", tw_idx, 0);
    @(negedge clk);
    sync_i = 1'b0;
    check("sync-only cnt", sample_cnt, 0);
    check("sync-only no out", out_valid, 0);
    set_x(smp[1][0][0], smp[1][0][1]); valid_i = 1'b1; @(negedge clk);
    set_x(smp[1][1][0], smp[1][1][1]); @(negedge clk);
    check("sync n2 cnt", sample_cnt, 2);
    sync_i = 1'b1;
    set_x(smp[0][0][0], smp[0][0][1]);
    #1 check("sync+valid tw", tw_idx, 0);
    @(negedge clk);
    sync_i = 1'b0;
    for (int n = 1; n < N; n++) begin
      set_x(smp[0][n][0], smp[0][n][1]);
      @(negedge clk);
    end
    valid_i = 1'b0;
    drain(0, -1);

    // Saturation with full-scale negative operands.
    sat_mode = 1'b1;
    for (int n = 0; n < N; n++) begin
      set_x(-32768, -32768);
      valid_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
    drain(2, -1);
    check("sat flag", sat, 1);
    sat_mode = 1'b0;

    // Reset in the middle of a drain.
    send_frame(0);
    repeat (2) @(negedge clk);
    check("mid-drain bin", out_bin, 2);
    rstn = 1'b0;
    @(negedge clk);
    check("rst2 out_valid", out_valid, 0);
    check("rst2 out_re", out_re, 0);
    check("rst2 out_im", out_im, 0);
    check("rst2 out_chan", out_chan, 0);
    check("rst2 out_bin", out_bin, 0);
    check("rst2 out_last", out_last, 0);
    check("rst2 overflow", overflow, 0);
    check("rst2 sat", sat, 0);
    check("rst2 sample_cnt", sample_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
